// File: rtl/mdu_ctrl_if.sv
// Multiply/divide unit bundle: E-stage request side plus the HI/LO result and
// stall-unit status returned by the unit.
interface mdu_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic        cancel;
  logic [31:0] A;
  logic [31:0] B;
  logic        rd_hi;
  logic        busy;
  logic        hilo_busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] rdata;

  modport master (
    output start, op, cancel, A, B, rd_hi,
    input  busy, hilo_busy, HI, LO, rdata
  );

  modport slave (
    input  start, op, cancel, A, B, rd_hi,
    output busy, hilo_busy, HI, LO, rdata
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller owning the architectural HI/LO pair.
// Fixed latency: 5 cycles for mult/multu, 10 for div/divu; mthi/mtlo write in one edge.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   S_IDLE | no operation in flight; start may be accepted
//   S_BUSY | mult/div in flight; cnt counts down, commit when cnt == 1
module mdu_ctrl (
  input logic       clk,
  input logic       reset,
  mdu_ctrl_if.slave bus
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  localparam logic [3:0] MUL_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES = 4'd10;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] hi_q, lo_q;

  logic        busy, accept, accept_md, accept_mthi, accept_mtlo, commit;

  logic [63:0] prod;
  logic        is_signed, neg_a, neg_b, b_zero;
  logic [31:0] mag_a, mag_b, div_b, quo_u, rem_u, quo, rem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept_md) state_nxt = S_BUSY;
      S_BUSY:  if (cnt == 4'd1) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state == S_BUSY);
    accept      = bus.start & ~bus.cancel & ~busy;
    accept_md   = accept & (bus.op <= 3'd3);
    accept_mthi = accept & (bus.op == 3'd4);
    accept_mtlo = accept & (bus.op == 3'd5);
    commit      = busy & (cnt == 4'd1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= 4'd0;
      op_q <= 2'd0;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
    end else if (accept_md) begin
      cnt  <= bus.op[1] ? DIV_CYCLES : MUL_CYCLES;
      op_q <= bus.op[1:0];
      a_q  <= bus.A;
      b_q  <= bus.B;
    end else if (busy) begin
      cnt  <= cnt - 4'd1;
    end
  end

  // Signed division works on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  always_comb begin
    is_signed = ~op_q[0];
    if (is_signed) prod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    else           prod = {32'd0, a_q} * {32'd0, b_q};
    neg_a  = is_signed & a_q[31];
    neg_b  = is_signed & b_q[31];
    mag_a  = neg_a ? (~a_q + 32'd1) : a_q;
    mag_b  = neg_b ? (~b_q + 32'd1) : b_q;
    b_zero = (b_q == 32'd0);
    div_b  = b_zero ? 32'd1 : mag_b;
    quo_u  = mag_a / div_b;
    rem_u  = mag_a % div_b;
    quo    = (neg_a ^ neg_b) ? (~quo_u + 32'd1) : quo_u;
    rem    = neg_a ? (~rem_u + 32'd1) : rem_u;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (accept_mthi) begin
      hi_q <= bus.A;
    end else if (accept_mtlo) begin
      lo_q <= bus.A;
    end else if (commit) begin
      if (!op_q[1]) begin
        {hi_q, lo_q} <= prod;
      end else if (!b_zero) begin
        hi_q <= rem;
        lo_q <= quo;
      end
    end
  end

  assign bus.busy      = busy;
  assign bus.hilo_busy = bus.start | busy;
  assign bus.HI        = hi_q;
  assign bus.LO        = lo_q;
  assign bus.rdata     = bus.rd_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: driver pushes model results, a negedge monitor
// pops them when busy drops and tracks HI/LO/rdata against the model every cycle.
module tb_mdu_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;

  mdu_ctrl_if bus();

  mdu_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    bit          upd;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] arch_hi = 32'd0;
  logic [31:0] arch_lo = 32'd0;
  int          checks = 0;
  int          failures = 0;
  int          run_len = 0;
  bit          prev_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference behaviour straight from the arithmetic definitions.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int ia, ib;
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, pu, qu, ru;
    ia = int'(a);
    ib = int'(b);
    sa = longint'(ia);
    sb = longint'(ib);
    ua = {32'd0, a};
    ub = {32'd0, b};
    e.hi  = 32'd0;
    e.lo  = 32'd0;
    e.upd = 1'b1;
    e.lat = (op < 3'd2) ? 5 : 10;
    case (op)
      3'd0: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
      3'd1: begin pu = ua * ub; e.hi = pu[63:32]; e.lo = pu[31:0]; end
      3'd2: begin
        if (b == 32'd0) e.upd = 1'b0;
        else begin q = sa / sb; r = sa % sb; e.lo = q[31:0]; e.hi = r[31:0]; end
      end
      default: begin
        if (b == 32'd0) e.upd = 1'b0;
        else begin qu = ua / ub; ru = ua % ub; e.lo = qu[31:0]; e.hi = ru[31:0]; end
      end
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      run_len   = 0;
      prev_busy = 1'b0;
    end else begin
      if (bus.busy) begin
        run_len++;
      end else if (prev_busy) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow actual=commit expected=no_commit");
        end else begin
          e = sb_q.pop_front();
          chk("busy_cycles", 32'(run_len), 32'(e.lat));
          if (e.upd) begin
            arch_hi = e.hi;
            arch_lo = e.lo;
          end
        end
        run_len = 0;
      end
      prev_busy = bus.busy;
      chk("HI", bus.HI, arch_hi);
      chk("LO", bus.LO, arch_lo);
      chk("rdata", bus.rdata, bus.rd_hi ? arch_hi : arch_lo);
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.busy) begin
      checks++;
      failures++;
      $display("FAIL busy_timeout actual=busy expected=idle");
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit c);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.A      = a;
    bus.B      = b;
    bus.cancel = c;
    bus.rd_hi  = 1'($urandom_range(0, 1));
    if (!c && op < 3'd4) sb_q.push_back(model(op, a, b));
    #1 chk("hilo_busy_start", 32'(bus.hilo_busy), 32'd1);
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    if (!c && op == 3'd4) arch_hi = a;
    if (!c && op == 3'd5) arch_lo = a;
    chk("busy_after_accept", 32'(bus.busy), 32'(!c && op < 3'd4));
    wait_idle();
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    bit          rc;

    bus.start  = 1'b0;
    bus.op     = 3'd0;
    bus.cancel = 1'b0;
    bus.A      = 32'd0;
    bus.B      = 32'd0;
    bus.rd_hi  = 1'b0;

    #1;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_hilo_busy", 32'(bus.hilo_busy), 32'd0);
    chk("reset_HI", bus.HI, 32'd0);
    chk("reset_LO", bus.LO, 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;

    run_op(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0);
    chk("mult_HI", bus.HI, 32'hFFFF_FFFF);
    chk("mult_LO", bus.LO, 32'hFFFF_FFFE);
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    chk("multu_HI", bus.HI, 32'h0000_0001);
    chk("multu_LO", bus.LO, 32'hFFFF_FFFE);

    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_LO", bus.LO, 32'hFFFF_FFFD);
    chk("div_HI", bus.HI, 32'hFFFF_FFFF);
    run_op(3'd3, 32'd7, 32'd0, 1'b0);
    chk("divu0_LO", bus.LO, 32'hFFFF_FFFD);
    chk("divu0_HI", bus.HI, 32'hFFFF_FFFF);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("divovf_LO", bus.LO, 32'h8000_0000);
    chk("divovf_HI", bus.HI, 32'd0);

    run_op(3'd0, 32'd5, 32'd6, 1'b1);
    run_op(3'd4, 32'hDEAD_BEEF, 32'd0, 1'b1);
    chk("cancel_HI", bus.HI, 32'd0);
    chk("cancel_LO", bus.LO, 32'h8000_0000);

    // Second start lands in the 2nd busy cycle and must be dropped.
    bus.start = 1'b1; bus.op = 3'd0; bus.A = 32'd1000; bus.B = 32'hFFFF_FFFD; bus.cancel = 1'b0;
    sb_q.push_back(model(3'd0, 32'd1000, 32'hFFFF_FFFD));
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 3'd1; bus.A = 32'd77; bus.B = 32'd88;
    #1 chk("hilo_busy_ignored", 32'(bus.hilo_busy), 32'd1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle();
    chk("ignore_HI", bus.HI, 32'hFFFF_FFFF);
    chk("ignore_LO", bus.LO, 32'hFFFF_F448);

    run_op(3'd5, 32'h1234_5678, 32'd0, 1'b0);
    bus.rd_hi = 1'b0;
    #1;
    chk("mtlo_LO", bus.LO, 32'h1234_5678);
    chk("mtlo_busy", 32'(bus.busy), 32'd0);
    chk("mtlo_rdata", bus.rdata, 32'h1234_5678);
    run_op(3'd4, 32'hCAFE_F00D, 32'd0, 1'b0);
    chk("mthi_HI", bus.HI, 32'hCAFE_F00D);

    // Back-to-back: each run_op returns in the first idle cycle after commit.
    run_op(3'd0, 32'd12345, 32'd678, 1'b0);
    run_op(3'd3, 32'd1000, 32'd7, 1'b0);
    run_op(3'd1, 32'h8000_0001, 32'h7FFF_FFFF, 1'b0);

    // Async reset in the 4th busy cycle of a div.
    run_op(3'd4, 32'h0BAD_CAFE, 32'd0, 1'b0);
    bus.start = 1'b1; bus.op = 3'd2; bus.A = 32'd100; bus.B = 32'd7; bus.cancel = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #1 reset = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_HI", bus.HI, 32'd0);
    chk("abort_LO", bus.LO, 32'd0);
    arch_hi = 32'd0;
    arch_lo = 32'd0;
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    run_op(3'd0, 32'd3, 32'd4, 1'b0);
    chk("post_reset_LO", bus.LO, 32'd12);
    chk("post_reset_HI", bus.HI, 32'd0);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        3: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      rc = ($urandom_range(0, 7) == 0);
      run_op(rop, ra, rb, rc);
    end

    repeat (3) @(posedge clk);
    #1 chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
